sm3_msg_expnd_strm: RTL and testbench



---
 rtl/sm3_msg_expnd_strm.sv | 106 ++++++++++
 tb/tb_sm3_msg_expnd_strm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_expnd_strm.sv
// Streaming SM3 message expansion: loads 16 words, then emits 64 rounds of W_j / W'_j / T_j.
// Define SM3_EXPND_TJ_EN to drive tj_o from an internal rotating T_j register; otherwise tj_o is 0.
module sm3_msg_expnd_strm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        msg_valid_i,
  input  logic [31:0] msg_word_i,
  output logic        msg_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] wj_o,
  output logic [31:0] wjj_o,
  output logic [31:0] tj_o,
  output logic        round_sm_16_o,
  output logic [5:0]  round_o,
  output logic        last_o
);
  localparam int WIN_D = 16;

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t                  state, state_nxt;
  logic [WIN_D-1:0][31:0]  win;
  logic [3:0]              cnt;
  logic [5:0]              j;
  logic                    in_hs, out_hs, load_done;
  logic [31:0]             w_new, word_in;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // win[0..15] = W_j..W_{j+15}; this yields W_{j+16}
  assign w_new   = p1(win[0] ^ win[7] ^ rotl(win[13], 15)) ^ rotl(win[3], 7) ^ win[10];
  assign word_in = (state == LOAD) ? msg_word_i : w_new;

  always_comb begin
    state_nxt = state;
    in_hs     = 1'b0;
    out_hs    = 1'b0;
    case (state)
      LOAD: begin
        in_hs = msg_valid_i;
        if (in_hs && cnt == 4'd15) state_nxt = EXPAND;
      end
      EXPAND: begin
        out_hs = out_ready_i;
        if (out_hs && j == 6'd63) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    if (clr_i) state_nxt = LOAD;
  end

  assign load_done = in_hs && (cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      j     <= '0;
      win   <= '0;
    end else begin
      state <= state_nxt;
      // abort beats any handshake in the same cycle; window contents are left stale
      if (clr_i) begin
        cnt <= '0;
        j   <= '0;
      end else begin
        if (in_hs)     cnt <= cnt + 4'd1;
        if (load_done) j   <= '0;
        if (out_hs)    j   <= j + 6'd1;
        if (in_hs || out_hs) win <= {word_in, win[WIN_D-1:1]};
      end
    end
  end

  assign msg_ready_o   = (state == LOAD);
  assign out_valid_o   = (state == EXPAND);
  assign wj_o          = out_valid_o ? win[0] : '0;
  assign wjj_o         = out_valid_o ? (win[0] ^ win[4]) : '0;
  assign round_o       = j;
  assign round_sm_16_o = (j[5:4] == 2'b00);
  assign last_o        = out_valid_o && (j == 6'd63);

`ifdef SM3_EXPND_TJ_EN
  logic [31:0] tj;

  // holds T_j <<< (j mod 32); reloads the second constant at j=16
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i)  tj <= '0;
    else if (load_done)   tj <= 32'h79cc4519;
    else if (out_hs)      tj <= (j == 6'd15) ? 32'h9d8a7a87 : rotl(tj, 1);
  end

  assign tj_o = out_valid_o ? tj : '0;
`else
  assign tj_o = '0;
`endif

endmodule

// File: tb/tb_sm3_msg_expnd_strm.sv
// Directed bench for sm3_msg_expnd_strm: "abc" and a second block, stalls, load gaps, clr and mid-load reset.
module tb_sm3_msg_expnd_strm;
  logic        clk = 1'b0;
  logic        rst_n, clr_i, msg_valid_i, out_ready_i;
  logic [31:0] msg_word_i;
  logic        msg_ready_o, out_valid_o, round_sm_16_o, last_o;
  logic [31:0] wj_o, wjj_o, tj_o;
  logic [5:0]  round_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] blk  [16];
  logic [31:0] wref [68];

  always #5 clk = ~clk;

  sm3_msg_expnd_strm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr_i),
    .msg_valid_i   (msg_valid_i),
    .msg_word_i    (msg_word_i),
    .msg_ready_o   (msg_ready_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .wj_o          (wj_o),
    .wjj_o         (wjj_o),
    .tj_o          (tj_o),
    .round_sm_16_o (round_sm_16_o),
    .round_o       (round_o),
    .last_o        (last_o)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference expansion in the textbook W_j form
  task automatic build_ref();
    for (int k = 0; k < 16; k++) wref[k] = blk[k];
    for (int k = 16; k < 68; k++)
      wref[k] = p1(wref[k-16] ^ wref[k-9] ^ rotl(wref[k-3], 15)) ^ rotl(wref[k-13], 7) ^ wref[k-6];
  endtask

  task automatic set_abc();
    blk[0] = 32'h61626380;
    for (int k = 1; k < 15; k++) blk[k] = 32'h0;
    blk[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mr"},   {31'b0, msg_ready_o},   32'd1);
    chk({tag, "_ov"},   {31'b0, out_valid_o},   32'd0);
    chk({tag, "_wj"},   wj_o,                   32'h0);
    chk({tag, "_wjj"},  wjj_o,                  32'h0);
    chk({tag, "_tj"},   tj_o,                   32'h0);
    chk({tag, "_rnd"},  {26'b0, round_o},       32'd0);
    chk({tag, "_sm16"}, {31'b0, round_sm_16_o}, 32'd1);
    chk({tag, "_last"}, {31'b0, last_o},        32'd0);
  endtask

  task automatic load_block(input bit gaps, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      if (gaps && (i % 3 == 1)) begin
        msg_valid_i = 1'b0;
        msg_word_i  = 32'hdeadbeef;
        chk($sformatf("gap_ov_%0d", i), {31'b0, out_valid_o}, 32'd0);
        @(negedge clk);
      end
      msg_valid_i = 1'b1;
      msg_word_i  = blk[i];
      chk($sformatf("ld_mr_%0d", i), {31'b0, msg_ready_o}, 32'd1);
      chk($sformatf("ld_ov_%0d", i), {31'b0, out_valid_o}, 32'd0);
      @(negedge clk);
    end
    msg_valid_i = 1'b0;
  endtask

  task automatic run_expand(input bit stall, input int abort_at, input bit junk);
    int          j   = 0;
    int          cyc = 0;
    logic        rdy;
    logic [31:0] texp;
    while (j < 64 && cyc < 2000) begin
      if (j == abort_at) begin
        clr_i       = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk);
        clr_i       = 1'b0;
        out_ready_i = 1'b0;
        chk("clr_ov",  {31'b0, out_valid_o}, 32'd0);
        chk("clr_mr",  {31'b0, msg_ready_o}, 32'd1);
        chk("clr_rnd", {26'b0, round_o},     32'd0);
        return;
      end
      rdy         = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready_i = rdy;
      if (junk) begin
        msg_valid_i = 1'b1;
        msg_word_i  = $urandom;
      end
`ifdef SM3_EXPND_TJ_EN
      texp = rotl((j < 16) ? 32'h79cc4519 : 32'h7a879d8a, j % 32);
`else
      texp = 32'h0;
`endif
      chk($sformatf("ov_j%0d", j),   {31'b0, out_valid_o},   32'd1);
      chk($sformatf("mr_j%0d", j),   {31'b0, msg_ready_o},   32'd0);
      chk($sformatf("wj_j%0d", j),   wj_o,                   wref[j]);
      chk($sformatf("wjj_j%0d", j),  wjj_o,                  wref[j] ^ wref[j+4]);
      chk($sformatf("tj_j%0d", j),   tj_o,                   texp);
      chk($sformatf("rnd_j%0d", j),  {26'b0, round_o},       j);
      chk($sformatf("sm16_j%0d", j), {31'b0, round_sm_16_o}, {31'b0, (j < 16)});
      chk($sformatf("last_j%0d", j), {31'b0, last_o},        {31'b0, (j == 63)});
`ifdef SM3_EXPND_TJ_EN
      if (j == 0)  chk("tj_hand_0",  tj_o, 32'h79cc4519);
      if (j == 1)  chk("tj_hand_1",  tj_o, 32'hf3988a32);
      if (j == 16) chk("tj_hand_16", tj_o, 32'h9d8a7a87);
      if (j == 63) chk("tj_hand_63", tj_o, 32'h3d43cec5);
`endif
      @(negedge clk);
      cyc++;
      if (rdy) j++;
    end
    chk("exp_timeout", j, 64);
    out_ready_i = 1'b0;
    msg_valid_i = 1'b0;
    chk("end_ov",   {31'b0, out_valid_o}, 32'd0);
    chk("end_mr",   {31'b0, msg_ready_o}, 32'd1);
    chk("end_last", {31'b0, last_o},      32'd0);
  endtask

  // hand-computed "abc" reference points, checked on a no-stall pass
  task automatic run_abc_hand();
    load_block(1'b0, 16);
    out_ready_i = 1'b1;
    for (int j = 0; j < 64; j++) begin
      if (j == 0)  chk("abc_w0",   wj_o,  32'h61626380);
      if (j == 0)  chk("abc_wjj0", wjj_o, 32'h61626380);
      if (j == 16) chk("abc_w16",  wj_o,  32'h9092e200);
      if (j == 18) chk("abc_w18",  wj_o,  32'h000c0606);
      if (j == 19) chk("abc_w19",  wj_o,  32'h719c70ed);
      @(negedge clk);
    end
    out_ready_i = 1'b0;
    chk("abc_end_ov", {31'b0, out_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    clr_i       = 1'b0;
    msg_valid_i = 1'b0;
    msg_word_i  = 32'h0;
    out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst_in");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_out");

    // "abc", continuous handshakes
    set_abc();
    run_abc_hand();
    load_block(1'b0, 16);
    run_expand(1'b0, -1, 1'b0);

    // "abc" under random backpressure, junk on msg_valid_i during expansion
    load_block(1'b0, 16);
    run_expand(1'b1, -1, 1'b1);

    // gaps in msg_valid_i during load
    load_block(1'b1, 16);
    chk("gap_ov_rise", {31'b0, out_valid_o}, 32'd1);
    run_expand(1'b0, -1, 1'b0);

    // clr at j=30 with out_ready, then a fresh block
    load_block(1'b0, 16);
    run_expand(1'b0, 30, 1'b0);
    load_block(1'b0, 16);
    run_expand(1'b0, -1, 1'b0);

    // one-cycle reset mid-load after 7 words
    load_block(1'b0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst_mid");
    load_block(1'b0, 16);
    run_expand(1'b0, -1, 1'b0);

    // a second, non-sparse block under backpressure
    for (int k = 0; k < 16; k++) blk[k] = (k * 32'h01010101) ^ 32'h9e3779b9;
    build_ref();
    load_block(1'b1, 16);
    run_expand(1'b1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
